credit_tx: RTL
==============

# credit_tx

Upstream transmitter for the Avalon-ST credit link. It accepts a ready/valid Avalon-ST stream and forwards it beat-by-beat onto the credit interface, sending one beat per credit held. It tracks credits granted by the downstream credit receiver through `update_credit`/`credit`, and can return unused credits with `return_credit` after an idle timeout or on request. It sits directly upstream of the ready-to-credit receiver and drives that receiver's `avsi_*` and `return_credit` inputs.

## Interface
- `data_width`, 128, payload width
- `empty_width`, 4, empty field width
- `channel_width`, 10, channel field width
- `credit_width`, 5, width of the `credit` grant field; the receiver buffer holds at most 2**credit_width beats
- `idle_timeout`, 64, number of idle ACTIVE cycles before held credits are returned; 0 disables auto-return

Ports:
- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `avsi_channel/data/sop/eop/empty`  in  channel_width/data_width/1/1/empty_width  ready-based input beat
- `avsi_valid`  in  1  input beat valid
- `avsi_ready`  out  1  input may be accepted this cycle
- `avso_channel/data/sop/eop/empty`  out  as input  credit-side beat
- `avso_valid`  out  1  beat valid; there is no backpressure
- `update_credit`  in  1  credit grant strobe from receiver
- `credit`  in  credit_width  number of credits granted with the strobe
- `return_credit`  out  1  returns one credit per asserted cycle
- `flush_req`  in  1  single-cycle pulse requesting return of all held credits
- `credit_count`  out  credit_width+1  credits currently held
- `credit_error`  out  1  sticky flag, set on credit overflow

## Operation
- States:
  - INIT: waiting for the first grant.
  - ACTIVE: forwarding beats.
  - RETURN: returning held credits.
- Transitions:
  - INIT -> ACTIVE on the first `update_credit`.
  - ACTIVE -> RETURN when `credit_count` > 0 and either `flush_req` is high or the idle counter equals `idle_timeout` (with `idle_timeout` != 0).
  - RETURN -> ACTIVE in the cycle after the last returned credit, when the count reaches 0.
- `avsi_ready` = (state == ACTIVE) && (credit_count != 0) && !flush_req && !(timeout hit). It is derived from registers only, apart from the `flush_req` term.
- A beat is accepted when `avsi_valid && avsi_ready`. It is sent with `avso_valid` = 1 for exactly one cycle.
- `avso_empty` = `avsi_empty` when `eop` is set, and 0 otherwise.
- Credit arithmetic, counter width credit_width+1:
  - next = count + (update_credit ? credit : 0) − accept − return_credit_issue.
  - If the sum exceeds 2**credit_width, the count saturates at 2**credit_width and `credit_error` is set.
  - `credit_error` clears only on reset.
- Grants arriving in INIT or RETURN are still added to the count.
- RETURN issue rule: while count > 0, issue one return per cycle and decrement the count. A grant arriving during RETURN extends the return sequence.
- Idle counter:
  - Increments each ACTIVE cycle with `avsi_valid` = 0.
  - Clears on any accepted beat, when `avsi_valid` = 1, or on leaving ACTIVE.
  - Saturates at `idle_timeout`.
- `flush_req` while count = 0 is ignored. `flush_req` in INIT or RETURN is ignored.

## Timing
- Reset values:
  - `avsi_ready` 0, `avso_valid` 0, all `avso_*` fields 0.
  - `return_credit` 0, `credit_count` 0, `credit_error` 0.
  - State INIT, idle counter 0.
- Latency: a beat accepted in cycle N appears on `avso_*` in cycle N+1. Full throughput is 1 beat per cycle while credits last.
- Grant visibility: a grant in cycle N updates `credit_count` at N+1. `avsi_ready` can rise at N+1.
- Last credit: when the last credit is consumed in cycle N, `avsi_ready` = 0 in N+1. The exception is a simultaneous grant, which keeps `avsi_ready` = 1.
- Return timing: a return decided in cycle N drives `return_credit` = 1 in N+1, registered. `credit_count` has already been decremented at N+1.
- Reset mid-operation: asserting `reset_n` = 0 immediately clears all state. Held credits are lost; the receiver resets on the same `reset_n` and re-grants.

## Test plan
- Credit exhaustion: reset, receiver grants `credit` = 31, source streams 40 back-to-back beats -> exactly 31 `avso_valid` pulses on consecutive cycles, `avsi_ready` = 0 afterwards, `credit_count` = 0.
- Concurrent grant and send: count = 1, beat accepted in the same cycle as `update_credit` with `credit` = 2 -> count = 2 next cycle, `avsi_ready` stays 1, no bubble.
- Idle timeout: `idle_timeout` = 8, count = 5, `avsi_valid` = 0 -> after 8 idle cycles, `return_credit` high for 5 consecutive cycles, count = 0, state ACTIVE, `avsi_ready` = 0.
- Flush with grant: `flush_req` pulse at count = 3, `update_credit` with `credit` = 1 during RETURN -> 4 return pulses total, no beats accepted during RETURN.
- Overflow and packet fields:
  - count = 31, grant `credit` = 2 -> count = 32, `credit_error` = 1 and stays set.
  - Packet of 3 beats with `avsi_empty` = 4'h5 on every beat -> `avso_empty` = 0, 0, 5; `sop` on beat 1, `eop` on beat 3.
- Reset mid-stream: `reset_n` = 0 for 1 cycle during a burst -> all outputs 0, state INIT, `avsi_ready` stays 0 until the next `update_credit`.

Source files
------------

// File: rtl/credit_tx.sv
// Upstream transmitter for the Avalon-ST credit link: forwards ready/valid beats
// one per held credit, tracks grants, and returns unused credits on idle or flush.
module credit_tx #(
  parameter int unsigned data_width    = 128,
  parameter int unsigned empty_width   = 4,
  parameter int unsigned channel_width = 10,
  parameter int unsigned credit_width  = 5,
  parameter int unsigned idle_timeout  = 64
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [channel_width-1:0] avsi_channel,
  input  logic [data_width-1:0]    avsi_data,
  input  logic                     avsi_sop,
  input  logic                     avsi_eop,
  input  logic [empty_width-1:0]   avsi_empty,
  input  logic                     avsi_valid,
  output logic                     avsi_ready,
  output logic [channel_width-1:0] avso_channel,
  output logic [data_width-1:0]    avso_data,
  output logic                     avso_sop,
  output logic                     avso_eop,
  output logic [empty_width-1:0]   avso_empty,
  output logic                     avso_valid,
  input  logic                     update_credit,
  input  logic [credit_width-1:0]  credit,
  output logic                     return_credit,
  input  logic                     flush_req,
  output logic [credit_width:0]    credit_count,
  output logic                     credit_error
);

  localparam int unsigned CNT_W  = credit_width + 1;
  localparam int unsigned SUM_W  = credit_width + 2;
  localparam int unsigned IDLE_W = $clog2(idle_timeout + 2);
  localparam logic [SUM_W-1:0]  CNT_MAX  = SUM_W'(2 ** credit_width);
  localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(idle_timeout);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_ACTIVE,
    ST_RETURN
  } state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [IDLE_W-1:0]          idle_q, idle_d;
  logic                       err_q, err_d;
  logic                       ret_q, ret_d;
  logic                       vld_q, vld_d;
  logic [channel_width-1:0]   chan_q;
  logic [data_width-1:0]      data_q;
  logic                       sop_q, eop_q;
  logic [empty_width-1:0]     empty_q;

  logic                       timeout_hit;
  logic                       ready_c;
  logic                       accept;
  logic                       ret_issue;
  logic [SUM_W-1:0]           sum;

  // Credit bookkeeping, state sequencing and idle tracking
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idle_d      = '0;
    err_d       = err_q;
    timeout_hit = (idle_timeout != 0) && (state_q == ST_ACTIVE) && (idle_q == IDLE_SAT);
    ready_c     = (state_q == ST_ACTIVE) && (count_q != '0) && !flush_req && !timeout_hit;
    accept      = avsi_valid && ready_c;
    ret_issue   = (state_q == ST_RETURN) && (count_q != '0);
    ret_d       = ret_issue;
    vld_d       = accept;

    // accept and ret_issue both require a nonzero count, so no underflow
    sum = SUM_W'(count_q) + (update_credit ? SUM_W'(credit) : '0)
        - SUM_W'(accept) - SUM_W'(ret_issue);
    if (sum > CNT_MAX) begin
      count_d = CNT_W'(CNT_MAX);
      err_d   = 1'b1;
    end else begin
      count_d = CNT_W'(sum);
    end

    case (state_q)
      ST_INIT: begin
        if (update_credit) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if ((count_q != '0) && (flush_req || timeout_hit)) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        if ((count_q == '0) && (count_d == '0)) state_d = ST_ACTIVE;
      end
      default: state_d = ST_INIT;
    endcase

    if ((state_q == ST_ACTIVE) && (state_d == ST_ACTIVE) && !avsi_valid) begin
      idle_d = (idle_q == IDLE_SAT) ? idle_q : idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      count_q <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      ret_q   <= 1'b0;
      vld_q   <= 1'b0;
      chan_q  <= '0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
      vld_q   <= vld_d;
      if (accept) begin
        chan_q  <= avsi_channel;
        data_q  <= avsi_data;
        sop_q   <= avsi_sop;
        eop_q   <= avsi_eop;
        empty_q <= avsi_eop ? avsi_empty : '0;
      end
    end
  end

  assign avsi_ready    = ready_c;
  assign avso_channel  = chan_q;
  assign avso_data     = data_q;
  assign avso_sop      = sop_q;
  assign avso_eop      = eop_q;
  assign avso_empty    = empty_q;
  assign avso_valid    = vld_q;
  assign return_credit = ret_q;
  assign credit_count  = count_q;
  assign credit_error  = err_q;

endmodule
